// File: rtl/pid_pkg.sv
// Shared fixed-point definitions for the fuzzy adaptive PID loop.
package pid_pkg;

  localparam int DATA_W = 32;

  // Saturation is symmetric, so the most-negative code never appears and negation is always safe.
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = -SAT_MAX;

  // Clamp a DATA_W+1 bit difference into the symmetric DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_sub(input logic signed [DATA_W:0] x);
    logic signed [DATA_W-1:0] r;
    if (x > (DATA_W+1)'(SAT_MAX))
      r = SAT_MAX;
    else if (x < (DATA_W+1)'(SAT_MIN))
      r = SAT_MIN;
    else
      r = x[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/position_error_sampler_if.sv
// Sample strobe, position inputs and error/derivative outputs of the sampler.
interface position_error_sampler_if #(parameter int DATA_W = pid_pkg::DATA_W);
  logic                     clk_100k_enable;
  logic signed [DATA_W-1:0] target_pos;
  logic signed [DATA_W-1:0] actual_pos;
  logic signed [DATA_W-1:0] error_pos;
  logic signed [DATA_W-1:0] delta_error;
  logic                     sample_valid;
  logic                     sign_change;

  modport master (
    output clk_100k_enable, target_pos, actual_pos,
    input  error_pos, delta_error, sample_valid, sign_change
  );

  modport slave (
    input  clk_100k_enable, target_pos, actual_pos,
    output error_pos, delta_error, sample_valid, sign_change
  );
endinterface

// File: rtl/position_error_sampler_moving_average.sv
// Boxcar average of the last 2^AVG_LOG2 samples, zero-filled after reset.
module moving_average #(
  parameter int DATA_W   = 32,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] out_data
);
  localparam int N  = 1 << AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = DATA_W + AVG_LOG2;

  logic signed [DATA_W-1:0] win [N];
  logic [PW-1:0]            ptr;
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     sum_next;

  // win[ptr] is the oldest entry; it is replaced by the incoming sample.
  assign sum_next = sum + SW'(in_data) - SW'(win[ptr]);

  // Circular buffer write, running sum and floor-rounded average.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      ptr      <= '0;
      sum      <= '0;
      out_data <= '0;
    end else if (in_valid) begin
      win[ptr] <= in_data;
      ptr      <= (ptr == PW'(N-1)) ? '0 : ptr + 1'b1;
      sum      <= sum_next;
      out_data <= DATA_W'(sum_next >>> AVG_LOG2);
    end
  end
endmodule

// File: rtl/position_error_sampler.sv
// Samples target/actual position on each strobe and produces a saturated,
// deadbanded error, an averaged error derivative and a sign-flip pulse.
// Three register stages; outputs update three clocks after the strobe.
module position_error_sampler #(
  parameter int          DATA_W   = pid_pkg::DATA_W,
  parameter int          AVG_LOG2 = 2,
  parameter int unsigned DEADBAND = 0
) (
  input logic clk,
  input logic reset,
  position_error_sampler_if.slave bus
);
  import pid_pkg::sat_sub;

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_err;
  logic signed [DATA_W:0]   raw_diff;

  logic [DATA_W-1:0]        s1_mag;
  logic signed [DATA_W-1:0] err_db;
  logic signed [DATA_W:0]   err_diff;
  logic signed [DATA_W-1:0] d_next;

  logic                     s2_valid;
  logic signed [DATA_W-1:0] s2_err;
  logic signed [DATA_W-1:0] s2_d;
  logic                     s2_first;
  logic signed [DATA_W-1:0] prev_err;
  logic                     primed;

  logic signed [DATA_W-1:0] error_pos_q;
  logic                     sample_valid_q;
  logic                     sign_change_q;
  logic                     prev_sign;
  logic signed [DATA_W-1:0] avg_out;

  assign raw_diff = (DATA_W+1)'(bus.target_pos) - (DATA_W+1)'(bus.actual_pos);

  // S1: capture the saturated raw error only on the strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_err   <= '0;
    end else begin
      s1_valid <= bus.clk_100k_enable;
      if (bus.clk_100k_enable) s1_err <= sat_sub(raw_diff);
    end
  end

  assign s1_mag   = s1_err[DATA_W-1] ? DATA_W'(-s1_err) : DATA_W'(s1_err);
  assign err_db   = (s1_mag <= DATA_W'(DEADBAND)) ? '0 : s1_err;
  assign err_diff = (DATA_W+1)'(err_db) - (DATA_W+1)'(prev_err);
  assign d_next   = primed ? sat_sub(err_diff) : '0;

  // S2: deadband, first-difference against the previous error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_err   <= '0;
      s2_d     <= '0;
      s2_first <= 1'b0;
      prev_err <= '0;
      primed   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err   <= err_db;
        s2_d     <= d_next;
        s2_first <= ~primed;
        prev_err <= err_db;
        primed   <= 1'b1;
      end
    end
  end

  // S3: publish error and sign-flip pulse; zero counts as non-negative.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_pos_q    <= '0;
      sample_valid_q <= 1'b0;
      sign_change_q  <= 1'b0;
      prev_sign      <= 1'b0;
    end else begin
      sample_valid_q <= s2_valid;
      sign_change_q  <= s2_valid && !s2_first && (prev_sign != s2_err[DATA_W-1]);
      if (s2_valid) begin
        error_pos_q <= s2_err;
        prev_sign   <= s2_err[DATA_W-1];
      end
    end
  end

  moving_average #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s2_valid),
    .in_data  (s2_d),
    .out_data (avg_out)
  );

  assign bus.error_pos    = error_pos_q;
  assign bus.delta_error  = avg_out;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sign_change  = sign_change_q;
endmodule

// File: tb/tb_position_error_sampler.sv
// Two sampler instances (no deadband / deadband 10) driven with identical
// stimulus; a reference model pushes expected samples, a monitor pops them.
module tb_position_error_sampler;

  localparam longint SMAX = 64'sd2147483647;

  typedef struct {
    longint err;
    longint delta;
    longint sc;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  exp_t   q [2][$];
  longint db [2] = '{0, 10};
  bit     m_primed [2];
  bit     m_neg [2];
  longint m_prev [2];
  longint m_win [2][4];
  longint m_sum [2];
  longint last_err [2];
  longint last_delta [2];

  logic signed [31:0] obs_err [2];
  logic signed [31:0] obs_delta [2];
  logic               obs_sv [2];
  logic               obs_sc [2];

  position_error_sampler_if #(.DATA_W(32)) ifa ();
  position_error_sampler_if #(.DATA_W(32)) ifb ();

  position_error_sampler #(.DATA_W(32), .AVG_LOG2(2), .DEADBAND(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  position_error_sampler #(.DATA_W(32), .AVG_LOG2(2), .DEADBAND(10)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  assign obs_err[0] = ifa.error_pos;   assign obs_err[1] = ifb.error_pos;
  assign obs_delta[0] = ifa.delta_error; assign obs_delta[1] = ifb.delta_error;
  assign obs_sv[0] = ifa.sample_valid; assign obs_sv[1] = ifb.sample_valid;
  assign obs_sc[0] = ifa.sign_change;  assign obs_sc[1] = ifb.sign_change;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint sat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < -SMAX) return -SMAX;
    return x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      m_primed[i] = 0; m_neg[i] = 0; m_prev[i] = 0; m_sum[i] = 0;
      for (int k = 0; k < 4; k++) m_win[i][k] = 0;
    end
  endtask

  task automatic model_push(input int i, input longint t, input longint a, input longint at_cyc);
    longint raw, err, d, oldest;
    exp_t e;
    raw = sat(t - a);
    err = (raw <= db[i] && raw >= -db[i]) ? 0 : raw;
    d = m_primed[i] ? sat(err - m_prev[i]) : 0;
    e.sc = (m_primed[i] && (m_neg[i] != (err < 0))) ? 1 : 0;
    m_prev[i] = err;
    m_neg[i] = (err < 0);
    m_primed[i] = 1;
    oldest = m_win[i][3];
    for (int k = 3; k > 0; k--) m_win[i][k] = m_win[i][k-1];
    m_win[i][0] = d;
    m_sum[i] = m_sum[i] + d - oldest;
    e.err = err;
    e.delta = m_sum[i] >>> 2;
    e.cyc = at_cyc;
    q[i].push_back(e);
  endtask

  // Called at a negedge; the strobe is sampled at the following posedge.
  task automatic strobe(input logic signed [31:0] t, input logic signed [31:0] a);
    ifa.clk_100k_enable = 1'b1; ifa.target_pos = t; ifa.actual_pos = a;
    ifb.clk_100k_enable = 1'b1; ifb.target_pos = t; ifb.actual_pos = a;
    for (int i = 0; i < 2; i++) model_push(i, longint'(t), longint'(a), cyc + 3);
    @(negedge clk);
    ifa.clk_100k_enable = 1'b0;
    ifb.clk_100k_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      chk("reset_error_pos", obs_err[i], 0);
      chk("reset_delta_error", obs_delta[i], 0);
      chk("reset_sample_valid", obs_sv[i], 0);
      chk("reset_sign_change", obs_sc[i], 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle(1);
  endtask

  // Monitor: pop one expectation per sample_valid pulse and compare.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        chk("sign_change_without_valid", obs_sc[i] && !obs_sv[i], 0);
        if (obs_sv[i]) begin
          if (q[i].size() == 0) begin
            chk("unexpected_sample_valid", 1, 0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            chk("latency_cycle", cyc, e.cyc);
            chk("error_pos", obs_err[i], e.err);
            chk("delta_error", obs_delta[i], e.delta);
            chk("sign_change", obs_sc[i], e.sc);
            last_err[i] = obs_err[i];
            last_delta[i] = obs_delta[i];
          end
        end
      end
    end
  end

  initial begin
    ifa.clk_100k_enable = 1'b0; ifa.target_pos = '0; ifa.actual_pos = '0;
    ifb.clk_100k_enable = 1'b0; ifb.target_pos = '0; ifb.actual_pos = '0;
    model_clear();

    // first sample after reset
    do_reset();
    strobe(1000, 400);
    idle(6);
    chk("first_err_600", last_err[0], 600);
    chk("first_delta_0", last_delta[0], 0);

    // ramp, back-to-back strobes: delta 0,25,50,75,100
    do_reset();
    for (int k = 0; k < 5; k++) strobe(32'(k * 100), 0);
    idle(6);
    chk("ramp_delta_100", last_delta[0], 100);

    // sign flips: +50, -30, -10
    do_reset();
    strobe(50, 0); idle(2);
    strobe(0, 30); idle(3);
    strobe(-10, 0); idle(6);
    chk("sign_err_minus10", last_err[0], -10);

    // saturation both ways
    do_reset();
    strobe(32'sh7FFFFFFF, -5); idle(2);
    strobe(32'sh80000001, 5); idle(6);
    chk("sat_err_min", last_err[0], -SMAX);

    // deadband edges: 10, -10, 11
    do_reset();
    strobe(10, 0); idle(1);
    strobe(-10, 0); idle(1);
    strobe(11, 0); idle(6);
    chk("deadband_err_11", last_err[1], 11);

    // random samples with random spacing
    for (int k = 0; k < 8; k++) begin
      strobe($urandom, $urandom);
      idle($urandom_range(0, 3));
    end
    idle(6);

    // reset while a sample sits in the pipeline
    strobe(100, 0);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    strobe(-20, 0);
    idle(6);
    chk("post_reset_err", last_err[0], -20);
    chk("post_reset_delta", last_delta[0], 0);

    for (int i = 0; i < 2; i++) chk("pending_expectations", q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
